hold_manager: RTL and testbench

Owns the table of climbing holds for the game screen. It keeps slot positions in world coordinates and runs the per-pixel hit test that drives the hold sprite. Once per frame it recycles holds that have scrolled below the view to new random positions above the topmost hold. It also answers grab queries from the climber logic through a req/ack handshake. It sits between the VGA timing/scroll logic and the pixel mixer, and serves the climber hand controller.

---
 rtl/hold_pkg.sv | 34 +++
 rtl/hold_manager_if.sv | 23 ++
 rtl/hold_lfsr.sv | 27 ++
 rtl/hold_manager.sv | 206 ++++++++++++++++++++
 tb/tb_hold_manager.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hold_pkg.sv
// Shared types, default geometry and LFSR constants for the hold table.
package hold_pkg;

  localparam int unsigned DefNumHolds = 8;
  localparam int unsigned DefWidth    = 48;
  localparam int unsigned DefHeight   = 20;
  localparam int unsigned DefScreenH  = 768;
  localparam int unsigned DefXRange   = 976;
  localparam int unsigned DefSpacing  = 96;

  // Right-shift Fibonacci form: taps 16,14,13,11 land on bits 0,2,3,5.
  localparam logic [15:0] LfsrSeed = 16'hACE1;
  localparam logic [15:0] LfsrTaps = 16'h002D;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRecycle = 2'd1,
    StGrab    = 2'd2,
    StAck     = 2'd3
  } state_e;

  typedef struct packed {
    logic signed [10:0] x;
    logic signed [11:0] y;
  } slot_t;

  // Rectangle containment on 14-bit signed operands; wide enough that no sum overflows.
  function automatic logic hit_test(logic signed [13:0] px, logic signed [13:0] py,
                                    logic signed [13:0] sx, logic signed [13:0] sy,
                                    logic signed [13:0] w, logic signed [13:0] h);
    return (px >= sx) && (px < sx + w) && (py >= sy) && (py < sy + h);
  endfunction

endpackage

// File: rtl/hold_manager_if.sv
// Grab query handshake between the climber hand controller and the hold table.
interface hold_manager_if #(
  parameter int unsigned ID_W = 3
) ();

  logic                grab_req;
  logic signed [10:0]  grab_x;
  logic signed [11:0]  grab_y;
  logic                grab_ack;
  logic                grab_hit;
  logic [ID_W-1:0]     grab_id;

  modport master (
    output grab_req, grab_x, grab_y,
    input  grab_ack, grab_hit, grab_id
  );

  modport slave (
    input  grab_req, grab_x, grab_y,
    output grab_ack, grab_hit, grab_id
  );

endinterface

// File: rtl/hold_lfsr.sv
// 16-bit Fibonacci LFSR that steps only when asked; feeds respawn x positions.
module hold_lfsr
  import hold_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        advance,
  output logic [15:0] value
);

  logic [15:0] lfsr_q;
  logic        feedback;

  assign feedback = ^(lfsr_q & LfsrTaps);

  // Shift right with the feedback bit entering at the top.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= LfsrSeed;
    end else if (advance) begin
      lfsr_q <= {feedback, lfsr_q[15:1]};
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/hold_manager.sv
// Hold table: per-pixel hit test for the sprite, vblank recycling of off-screen holds,
// and a sequential grab query for the climber.
module hold_manager
  import hold_pkg::*;
#(
  parameter int unsigned NUM_HOLDS = DefNumHolds,
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned HEIGHT    = DefHeight,
  parameter int unsigned SCREEN_H  = DefScreenH,
  parameter int unsigned X_RANGE   = DefXRange,
  parameter int unsigned SPACING   = DefSpacing
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [10:0]                  hcount,
  input  logic [9:0]                   vcount,
  input  logic signed [11:0]           screenx,
  input  logic signed [12:0]           screeny,
  input  logic                         frame_start,
  output logic                         exists,
  output logic [$clog2(NUM_HOLDS)-1:0] hold_id,
  hold_manager_if.slave                grab,
  output logic                         busy
);

  localparam int unsigned IdW = $clog2(NUM_HOLDS);

  localparam logic signed [13:0] W14  = 14'(WIDTH);
  localparam logic signed [13:0] H14  = 14'(HEIGHT);
  localparam logic signed [13:0] SH14 = 14'(SCREEN_H);

  slot_t              slot_q [NUM_HOLDS];
  logic signed [11:0] top_y_q;

  state_e             state_q, state_d;
  logic [IdW-1:0]     idx_q;
  logic               pending_q;
  logic signed [10:0] gx_q;
  logic signed [11:0] gy_q;
  logic               found_q;
  logic [IdW-1:0]     found_id_q;
  logic               grab_hit_q;
  logic [IdW-1:0]     grab_id_q;
  logic               exists_q;
  logic [IdW-1:0]     hold_id_q;

  logic [15:0]        lfsr_value;
  logic               unused_lfsr;
  logic               respawn;

  // ---------------------------------------------------------------------------
  // Pixel path
  // ---------------------------------------------------------------------------
  logic signed [13:0] px, py;
  logic               pix_hit;
  logic [IdW-1:0]     pix_idx;

  assign px = $signed({3'b000, hcount}) + $signed({{2{screenx[11]}}, screenx});
  assign py = $signed({4'b0000, vcount}) + $signed({screeny[12], screeny});

  // Parallel compare of every slot; scanning downward leaves the lowest hit index.
  always_comb begin
    pix_hit = 1'b0;
    pix_idx = '0;
    for (int i = int'(NUM_HOLDS) - 1; i >= 0; i--) begin
      if (hit_test(px, py,
                   $signed({{3{slot_q[i].x[10]}}, slot_q[i].x}),
                   $signed({{2{slot_q[i].y[11]}}, slot_q[i].y}),
                   W14, H14)) begin
        pix_hit = 1'b1;
        pix_idx = IdW'(i);
      end
    end
  end

  // Register the sprite outputs for one cycle of latency.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exists_q  <= 1'b0;
      hold_id_q <= '0;
    end else begin
      exists_q  <= pix_hit;
      hold_id_q <= pix_idx;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential slot walk shared by recycle and grab
  // ---------------------------------------------------------------------------
  slot_t              cur;
  logic signed [13:0] cur_x14, cur_y14;
  logic               last;
  logic               below_view;
  logic               grab_match;
  logic signed [11:0] new_y;
  logic signed [10:0] new_x;
  logic [9:0]         rnd;

  assign cur        = slot_q[idx_q];
  assign cur_x14    = $signed({{3{cur.x[10]}}, cur.x});
  assign cur_y14    = $signed({{2{cur.y[11]}}, cur.y});
  assign last       = (idx_q == IdW'(NUM_HOLDS - 1));
  assign below_view = (cur_y14 - $signed({screeny[12], screeny})) >= SH14;
  assign grab_match = hit_test($signed({{3{gx_q[10]}}, gx_q}), $signed({{2{gy_q[11]}}, gy_q}),
                               cur_x14, cur_y14, W14, H14);

  assign respawn = (state_q == StRecycle) && below_view;
  assign new_y   = top_y_q - 12'(SPACING);
  assign rnd     = lfsr_value[9:0];
  // A single subtraction folds the 10-bit value into 0..X_RANGE-1.
  assign new_x   = (rnd < 10'(X_RANGE)) ? {1'b0, rnd} : {1'b0, rnd - 10'(X_RANGE)};

  assign unused_lfsr = ^lfsr_value[15:10];

  hold_lfsr u_lfsr (
    .clock   (clock),
    .reset_n (reset_n),
    .advance (respawn),
    .value   (lfsr_value)
  );

  // Next-state decode; a pending or fresh frame always beats a grab.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (frame_start || pending_q) begin
          state_d = StRecycle;
        end else if (grab.grab_req) begin
          state_d = StGrab;
        end
      end
      StRecycle: if (last) state_d = StIdle;
      StGrab:    if (last) state_d = StAck;
      StAck:     state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // FSM state, slot index, pending frame flag and grab result registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      pending_q  <= 1'b0;
      gx_q       <= '0;
      gy_q       <= '0;
      found_q    <= 1'b0;
      found_id_q <= '0;
      grab_hit_q <= 1'b0;
      grab_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      // Idle always consumes a pending frame, so only busy states can set it.
      pending_q <= (state_q == StIdle) ? 1'b0 : (pending_q | frame_start);
      unique case (state_q)
        StIdle: begin
          idx_q      <= '0;
          found_q    <= 1'b0;
          found_id_q <= '0;
          if (state_d == StGrab) begin
            gx_q <= grab.grab_x;
            gy_q <= grab.grab_y;
          end
        end
        StRecycle: idx_q <= idx_q + IdW'(1);
        StGrab: begin
          idx_q <= idx_q + IdW'(1);
          if (grab_match && !found_q) begin
            found_q    <= 1'b1;
            found_id_q <= idx_q;
          end
          if (last) begin
            grab_hit_q <= found_q | grab_match;
            grab_id_q  <= found_q ? found_id_q : (grab_match ? idx_q : '0);
          end
        end
        StAck:   idx_q <= '0;
        default: ;
      endcase
    end
  end

  // Slot table and top-of-stack; only recycle writes, which keeps the display stable.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_HOLDS); i++) begin
        slot_q[i].x <= 11'(i * 112);
        slot_q[i].y <= 12'(int'(SCREEN_H) - (i + 1) * int'(SPACING));
      end
      top_y_q <= 12'(int'(SCREEN_H) - int'(NUM_HOLDS) * int'(SPACING));
    end else if (respawn) begin
      slot_q[idx_q].x <= new_x;
      slot_q[idx_q].y <= new_y;
      top_y_q         <= new_y;
    end
  end

  assign exists        = exists_q;
  assign hold_id       = hold_id_q;
  assign busy          = (state_q != StIdle);
  assign grab.grab_ack = (state_q == StAck);
  assign grab.grab_hit = grab_hit_q;
  assign grab.grab_id  = grab_id_q;

endmodule

// File: tb/tb_hold_manager.sv
// Directed bench for hold_manager: stimulus pushes expectations, one monitor compares.
module tb_hold_manager;

  typedef struct { string name; int hit; int id; int cyc; } grab_exp_t;
  typedef struct { string name; int ex; int id; } pix_exp_t;
  typedef struct { string name; int act; int exp; } chk_t;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic [10:0]        hcount;
  logic [9:0]         vcount;
  logic signed [11:0] screenx;
  logic signed [12:0] screeny;
  logic               frame_start;
  logic               exists;
  logic [2:0]         hold_id;
  logic               busy;

  hold_manager_if #(.ID_W(3)) gif ();

  hold_manager dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .hcount      (hcount),
    .vcount      (vcount),
    .screenx     (screenx),
    .screeny     (screeny),
    .frame_start (frame_start),
    .exists      (exists),
    .hold_id     (hold_id),
    .grab        (gif),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  grab_exp_t gq[$];
  pix_exp_t  pq[$];
  chk_t      cq[$];
  bit        pix_pend = 1'b0;
  bit        pix_seen;

  int exp_x_rest [6] = '{224, 336, 448, 560, 672, 784};
  int exp_y_rest [6] = '{480, 384, 288, 192, 96, 0};

  task automatic cmp(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pixel results, grab results on grab_ack, then queued direct observations.
  always @(posedge clock) begin
    pix_seen = pix_pend;
    #1;
    if (pix_seen) begin
      if (pq.size() == 0) begin
        cmp("pixel_queue_underflow", 0, 1);
      end else begin
        pix_exp_t p;
        p = pq.pop_front();
        cmp({p.name, "_exists"}, int'(exists), p.ex);
        cmp({p.name, "_hold_id"}, int'(hold_id), p.id);
      end
    end
    if (gif.grab_ack) begin
      if (gq.size() == 0) begin
        cmp("unexpected_grab_ack", 1, 0);
      end else begin
        grab_exp_t g;
        g = gq.pop_front();
        cmp({g.name, "_hit"}, int'(gif.grab_hit), g.hit);
        cmp({g.name, "_id"}, int'(gif.grab_id), g.id);
        cmp({g.name, "_ack_cycle"}, cyc, g.cyc);
      end
    end
    #1;
    while (cq.size() != 0) begin
      chk_t c;
      c = cq.pop_front();
      cmp(c.name, c.act, c.exp);
    end
  end

  task automatic chk(string name, int act, int exp);
    cq.push_back('{name, act, exp});
  endtask

  task automatic pix(string name, int h, int v, int ex, int id);
    @(negedge clock);
    hcount = 11'(h);
    vcount = 10'(v);
    pq.push_back('{name, ex, id});
    pix_pend = 1'b1;
    @(negedge clock);
    pix_pend = 1'b0;
  endtask

  task automatic grab_issue(string name, int x, int y, int hit, int id, int lat, bit with_frame);
    @(negedge clock);
    gif.grab_x   = 11'(x);
    gif.grab_y   = 12'(y);
    gif.grab_req = 1'b1;
    frame_start  = with_frame;
    gq.push_back('{name, hit, id, cyc + lat});
    @(negedge clock);
    frame_start = 1'b0;
  endtask

  task automatic grab_wait(string name);
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clock);
      #1;
      seen = gif.grab_ack;
    end
    if (!seen) chk({name, "_ack_timeout"}, 0, 1);
    @(negedge clock);
    gif.grab_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    hcount       = '0;
    vcount       = '0;
    screenx      = '0;
    screeny      = '0;
    frame_start  = 1'b0;
    gif.grab_req = 1'b0;
    gif.grab_x   = '0;
    gif.grab_y   = '0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    chk("rst_exists", int'(exists), 0);
    chk("rst_hold_id", int'(hold_id), 0);
    chk("rst_grab_ack", int'(gif.grab_ack), 0);
    chk("rst_grab_hit", int'(gif.grab_hit), 0);
    chk("rst_grab_id", int'(gif.grab_id), 0);
    chk("rst_busy", int'(busy), 0);

    // Pixel path against the reset table (slot0 at 0..47 x 672..691, slot7 at 784.. x 0..19).
    pix("pix_slot0", 10, 680, 1, 0);
    pix("pix_x_edge", 48, 680, 0, 0);
    pix("pix_corner", 47, 691, 1, 0);
    pix("pix_y_edge", 10, 692, 0, 0);
    pix("pix_slot7", 800, 5, 1, 7);

    // Grab queries against the reset table.
    grab_issue("grab_120_580", 120, 580, 1, 1, 9, 1'b0);
    grab_wait("grab_120_580");
    repeat (2) @(negedge clock);
    chk("grab_hit_held", int'(gif.grab_hit), 1);
    chk("grab_id_held", int'(gif.grab_id), 1);
    grab_issue("grab_60_600", 60, 600, 0, 0, 9, 1'b0);
    grab_wait("grab_60_600");

    // Recycle with the view raised 200 px: slots 0 and 1 fall below and respawn.
    screeny = -13'sd200;
    busy_cnt = 0;
    @(negedge clock);
    frame_start = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clock);
      #1;
      busy_cnt += int'(busy);
      if (k == 0) frame_start = 1'b0;
    end
    chk("recycle_busy_cycles", busy_cnt, 8);
    chk("slot0_y", int'($signed(dut.slot_q[0].y)), -96);
    chk("slot0_x", int'($signed(dut.slot_q[0].x)), 225);
    chk("slot1_y", int'($signed(dut.slot_q[1].y)), -192);
    chk("slot1_x", int'($signed(dut.slot_q[1].x)), 624);
    chk("top_y", int'($signed(dut.top_y_q)), -192);
    chk("lfsr_after_two", int'(dut.u_lfsr.lfsr_q), 32'hAB38);
    for (int i = 2; i < 8; i++) begin
      chk($sformatf("slot%0d_x_kept", i), int'($signed(dut.slot_q[i].x)), exp_x_rest[i-2]);
      chk($sformatf("slot%0d_y_kept", i), int'($signed(dut.slot_q[i].y)), exp_y_rest[i-2]);
    end
    pix("pix_new_slot0", 230, 109, 1, 0);
    pix("pix_new_slot1", 630, 10, 1, 1);

    // Grab and frame_start together: recycle first, grab sees the moved slot0.
    do_reset();
    grab_issue("grab_with_frame", 230, -91, 1, 0, 18, 1'b1);
    grab_wait("grab_with_frame");

    // frame_start mid-grab is held pending and runs right after the ack.
    grab_issue("grab_pending", 120, 580, 0, 0, 9, 1'b0);
    repeat (2) @(negedge clock);
    frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0;
    grab_wait("grab_pending");
    for (int k = 0; k < 10; k++) begin
      @(posedge clock);
      #1;
      chk($sformatf("pending_busy_%0d", k), int'(busy), (k >= 1 && k <= 8) ? 1 : 0);
    end

    // Asynchronous reset in the middle of a recycle.
    do_reset();
    screeny = -13'sd200;
    hcount  = 11'd230;
    vcount  = 10'd685;
    grab_issue("grab_before_rst", 120, 580, 1, 1, 9, 1'b0);
    grab_wait("grab_before_rst");
    @(negedge clock);
    frame_start = 1'b1;
    @(posedge clock);
    #1;
    frame_start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("pre_rst_busy", int'(busy), 1);
    chk("pre_rst_exists", int'(exists), 1);
    chk("pre_rst_hold_id", int'(hold_id), 2);
    chk("pre_rst_slot0_y", int'($signed(dut.slot_q[0].y)), -96);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_exists", int'(exists), 0);
    chk("mid_rst_hold_id", int'(hold_id), 0);
    chk("mid_rst_grab_ack", int'(gif.grab_ack), 0);
    chk("mid_rst_grab_hit", int'(gif.grab_hit), 0);
    chk("mid_rst_grab_id", int'(gif.grab_id), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_slot0_y", int'($signed(dut.slot_q[0].y)), 672);
    chk("mid_rst_slot0_x", int'($signed(dut.slot_q[0].x)), 0);
    chk("mid_rst_top_y", int'($signed(dut.top_y_q)), 0);
    chk("mid_rst_lfsr", int'(dut.u_lfsr.lfsr_q), 32'hACE1);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    repeat (2) @(negedge clock);
    chk("grab_queue_drained", gq.size(), 0);
    chk("pixel_queue_drained", pq.size(), 0);
    repeat (4) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
